// File: rtl/dram_bank_array_if.sv
// dram_bank_array_if: command/data bus between the DRAM controller (master)
// and the device-side responder (slave).
interface dram_bank_array_if #(
   parameter int unsigned NUM_OF_BANKS = 8,
   parameter int unsigned NUM_OF_ROWS  = 128,
   parameter int unsigned NUM_OF_COLS  = 8,
   parameter int unsigned DATA_WIDTH   = 1
);
   logic [1:0]              cmd;
   logic                    wr_en;
   logic                    refresh;
   logic [NUM_OF_BANKS-1:0] bank_sel;
   logic [NUM_OF_ROWS-1:0]  row_sel;
   logic [NUM_OF_COLS-1:0]  col_sel;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH-1:0]   dram_data_out;
   logic                    rd_valid;
   logic                    ready;
   logic                    cmd_err;

   modport master (
      output cmd, wr_en, refresh, bank_sel, row_sel, col_sel, wr_data,
      input  dram_data_out, rd_valid, ready, cmd_err
   );

   modport slave (
      input  cmd, wr_en, refresh, bank_sel, row_sel, col_sel, wr_data,
      output dram_data_out, rd_valid, ready, cmd_err
   );
endinterface

// File: rtl/dram_bank_array.sv
// dram_bank_array: device-side DRAM responder with per-bank open-row tracking.
// Define DRAM_BANK_ARRAY_TIMING_CHECK_EN to build the tRCD/tRP/tRFC countdowns.
module dram_bank_array #(
   parameter int unsigned NUM_OF_BANKS = 8,
   parameter int unsigned NUM_OF_ROWS  = 128,
   parameter int unsigned NUM_OF_COLS  = 8,
   parameter int unsigned DATA_WIDTH   = 1,
   parameter int unsigned T_RCD        = 2,
   parameter int unsigned T_RP         = 2,
   parameter int unsigned T_RFC        = 8
) (
   input  logic             clk,
   input  logic             rst,
   dram_bank_array_if.slave bus
);
   localparam int unsigned BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
   localparam int unsigned ROW_W  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
   localparam int unsigned COL_W  = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
   localparam int unsigned DEPTH  = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVATING,
      S_ACTIVE,
      S_PRECHARGING
   } bank_state_t;

   typedef enum logic [1:0] {
      C_NOP = 2'b00,
      C_ACT = 2'b01,
      C_RW  = 2'b10,
      C_PRE = 2'b11
   } cmd_t;

   if (T_RCD == 0 || T_RP == 0 || T_RFC == 0) begin : g_bad_timing
      $error("dram_bank_array: T_RCD, T_RP and T_RFC must be at least 1");
   end

   function automatic logic [BANK_W-1:0] enc_bank(input logic [NUM_OF_BANKS-1:0] sel);
      logic [BANK_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_OF_BANKS; i++)
         if (sel[i]) idx = idx | BANK_W'(i);
      return idx;
   endfunction

   function automatic logic [ROW_W-1:0] enc_row(input logic [NUM_OF_ROWS-1:0] sel);
      logic [ROW_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_OF_ROWS; i++)
         if (sel[i]) idx = idx | ROW_W'(i);
      return idx;
   endfunction

   function automatic logic [COL_W-1:0] enc_col(input logic [NUM_OF_COLS-1:0] sel);
      logic [COL_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_OF_COLS; i++)
         if (sel[i]) idx = idx | COL_W'(i);
      return idx;
   endfunction

   bank_state_t             r_state     [NUM_OF_BANKS];
   bank_state_t             w_state_nxt [NUM_OF_BANKS];
   logic [ROW_W-1:0]        r_row       [NUM_OF_BANKS];
   logic [ROW_W-1:0]        w_row_nxt   [NUM_OF_BANKS];
   logic [NUM_OF_BANKS-1:0] w_cnt_zero;
   logic [NUM_OF_BANKS-1:0] w_idle;
   logic [NUM_OF_BANKS-1:0] w_active;

   logic                    r_ready;
   logic                    w_ready_nxt;
   logic                    r_rd_valid;
   logic                    w_rd_nxt;
   logic                    r_cmd_err;
   logic                    w_err_nxt;
   logic                    w_we;
   logic [DATA_WIDTH-1:0]   r_dout;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   cmd_t                    w_cmd;
   logic                    w_bank_oh;
   logic                    w_row_oh;
   logic                    w_col_oh;
   logic [BANK_W-1:0]       w_bank;
   logic [ROW_W-1:0]        w_row;
   logic [COL_W-1:0]        w_col;
   logic [ADDR_W-1:0]       w_addr;

`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
   localparam int unsigned T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);
   localparam int unsigned RFC_W = $clog2(T_RFC + 1);

   logic [CNT_W-1:0]        r_cnt     [NUM_OF_BANKS];
   logic [CNT_W-1:0]        w_cnt_nxt [NUM_OF_BANKS];
   logic [RFC_W-1:0]        r_rfc_cnt;
   logic [RFC_W-1:0]        w_rfc_nxt;
`endif

   assign w_cmd     = cmd_t'(bus.cmd);
   assign w_bank_oh = $onehot(bus.bank_sel);
   assign w_row_oh  = $onehot(bus.row_sel);
   assign w_col_oh  = $onehot(bus.col_sel);
   assign w_bank    = enc_bank(bus.bank_sel);
   assign w_row     = enc_row(bus.row_sel);
   assign w_col     = enc_col(bus.col_sel);
   assign w_addr    = ADDR_W'((32'(w_bank) * NUM_OF_ROWS + 32'(r_row[w_bank])) * NUM_OF_COLS
                              + 32'(w_col));

   // A bank whose countdown hits zero is already usable on this edge, so the
   // edge-N command sees the target state exactly T cycles after it was entered.
   always_comb begin
      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
         w_cnt_zero[b] = (r_cnt[b] == '0);
`else
         w_cnt_zero[b] = 1'b1;
`endif
         w_idle[b]   = (r_state[b] == S_IDLE) ||
                       ((r_state[b] == S_PRECHARGING) && w_cnt_zero[b]);
         w_active[b] = (r_state[b] == S_ACTIVE) ||
                       ((r_state[b] == S_ACTIVATING) && w_cnt_zero[b]);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_ready_nxt = r_ready;
      w_err_nxt   = 1'b0;
      w_rd_nxt    = 1'b0;
      w_we        = 1'b0;
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
      w_cnt_nxt   = r_cnt;
      w_rfc_nxt   = r_rfc_cnt;
`endif

      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
         if (r_state[b] == S_ACTIVATING && w_cnt_zero[b])
            w_state_nxt[b] = S_ACTIVE;
         else if (r_state[b] == S_PRECHARGING && w_cnt_zero[b])
            w_state_nxt[b] = S_IDLE;
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
         else if (r_state[b] == S_ACTIVATING || r_state[b] == S_PRECHARGING)
            w_cnt_nxt[b] = r_cnt[b] - CNT_W'(1);
`endif
      end

      if (!r_ready) begin
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
         if (r_rfc_cnt == '0) w_ready_nxt = 1'b1;
         else                 w_rfc_nxt   = r_rfc_cnt - RFC_W'(1);
`else
         w_ready_nxt = 1'b1;
`endif
      end

      if (!r_ready) begin
         w_err_nxt = (w_cmd != C_NOP) || bus.refresh;
      end else if (bus.refresh) begin
         if (w_cmd != C_NOP || !(&w_idle)) begin
            w_err_nxt = 1'b1;
         end else begin
            w_ready_nxt = 1'b0;
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
            w_rfc_nxt   = RFC_W'(T_RFC - 1);
`endif
         end
      end else begin
         case (w_cmd)
            C_ACT: begin
               if (!w_bank_oh || !w_row_oh || !w_idle[w_bank]) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_state_nxt[w_bank] = S_ACTIVATING;
                  w_row_nxt[w_bank]   = w_row;
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
                  w_cnt_nxt[w_bank]   = CNT_W'(T_RCD - 1);
`endif
               end
            end
            C_RW: begin
               if (!w_bank_oh || !w_col_oh || !w_active[w_bank])
                  w_err_nxt = 1'b1;
               else if (bus.wr_en)
                  w_we = 1'b1;
               else
                  w_rd_nxt = 1'b1;
            end
            C_PRE: begin
               if (!w_bank_oh) begin
                  w_err_nxt = 1'b1;
               end else if (w_active[w_bank]) begin
                  w_state_nxt[w_bank] = S_PRECHARGING;
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
                  w_cnt_nxt[w_bank]   = CNT_W'(T_RP - 1);
`endif
               end else if (!w_idle[w_bank]) begin
                  w_err_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
            r_state[b] <= S_IDLE;
            r_row[b]   <= '0;
         end
         r_ready    <= 1'b1;
         r_rd_valid <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_dout     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_row      <= w_row_nxt;
         r_ready    <= w_ready_nxt;
         r_rd_valid <= w_rd_nxt;
         r_cmd_err  <= w_err_nxt;
         if (w_rd_nxt) r_dout <= r_mem[w_addr];
      end
   end

`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned b = 0; b < NUM_OF_BANKS; b++) r_cnt[b] <= '0;
         r_rfc_cnt <= '0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_rfc_cnt <= w_rfc_nxt;
      end
   end
`endif

   // Storage is deliberately not reset; contents survive reset and refresh.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_addr] <= bus.wr_data;
   end

   assign bus.dram_data_out = r_dout;
   assign bus.rd_valid      = r_rd_valid;
   assign bus.ready         = r_ready;
   assign bus.cmd_err       = r_cmd_err;
endmodule

// File: tb/tb_dram_bank_array.sv
// tb_dram_bank_array: scoreboard bench for dram_bank_array with a timestamp-based
// bank model; honours DRAM_BANK_ARRAY_TIMING_CHECK_EN like the design.
module tb_dram_bank_array;
   localparam int unsigned NB    = 8;
   localparam int unsigned NR    = 128;
   localparam int unsigned NC    = 8;
   localparam int unsigned T_RCD = 2;
   localparam int unsigned T_RP  = 2;
   localparam int unsigned T_RFC = 8;
`ifdef DRAM_BANK_ARRAY_TIMING_CHECK_EN
   localparam int E_RCD = T_RCD;
   localparam int E_RP  = T_RP;
   localparam int E_RFC = T_RFC;
`else
   localparam int E_RCD = 1;
   localparam int E_RP  = 1;
   localparam int E_RFC = 1;
`endif

   typedef struct {
      longint cyc;
      bit     err;
      bit     chk;
      logic   data;
   } resp_t;

   typedef struct {
      longint cyc;
      logic   val;
   } rdy_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   longint edge_no = 0;
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   resp_t eq[$];
   rdy_t  rq[$];

   // Reference model: a bank is described by whether a row is open and the
   // edge from which it becomes usable (active) or reusable (idle).
   bit     open_m  [NB];
   longint act_at  [NB];
   longint idle_at [NB];
   int     row_m   [NB];
   longint rf_end;
   logic   mem_m [int];

   dram_bank_array_if #(
      .NUM_OF_BANKS (NB),
      .NUM_OF_ROWS  (NR),
      .NUM_OF_COLS  (NC),
      .DATA_WIDTH   (1)
   ) bus ();

   dram_bank_array #(
      .NUM_OF_BANKS (NB),
      .NUM_OF_ROWS  (NR),
      .NUM_OF_COLS  (NC),
      .DATA_WIDTH   (1),
      .T_RCD        (T_RCD),
      .T_RP         (T_RP),
      .T_RFC        (T_RFC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   function automatic int oh_index(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   function automatic bit m_idle(input int b, input longint e);
      return !open_m[b] && e >= idle_at[b];
   endfunction

   function automatic bit m_active(input int b, input longint e);
      return open_m[b] && e >= act_at[b];
   endfunction

   function automatic bit m_all_idle(input longint e);
      for (int b = 0; b < NB; b++)
         if (!m_idle(b, e)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         open_m[b]  = 1'b0;
         act_at[b]  = 0;
         idle_at[b] = 0;
         row_m[b]   = 0;
      end
      rf_end = 0;
   endtask

   task automatic issue(input logic [1:0] c, input logic we, input logic rf,
                        input logic [NB-1:0] bs, input logic [NR-1:0] rs,
                        input logic [NC-1:0] cs, input logic wd);
      longint e;
      bit     err, rd, chk;
      logic   dat;
      int     b, k;
      @(negedge clk);
      bus.cmd = c; bus.wr_en = we; bus.refresh = rf;
      bus.bank_sel = bs; bus.row_sel = rs; bus.col_sel = cs; bus.wr_data = wd;
      e = edge_no + 1;
      err = 1'b0; rd = 1'b0; chk = 1'b0; dat = 1'b0;
      b = oh_index(NR'(bs));
      if (e <= rf_end) begin
         err = (c != 2'b00) || rf;
      end else if (rf) begin
         if (c != 2'b00 || !m_all_idle(e)) err = 1'b1;
         else rf_end = e + E_RFC;
      end else if (c != 2'b00) begin
         if ($countones(bs) != 1) begin
            err = 1'b1;
         end else if (c == 2'b01) begin
            if ($countones(rs) != 1 || !m_idle(b, e)) err = 1'b1;
            else begin
               open_m[b] = 1'b1;
               act_at[b] = e + E_RCD;
               row_m[b]  = oh_index(rs);
            end
         end else if (c == 2'b10) begin
            if ($countones(cs) != 1 || !m_active(b, e)) err = 1'b1;
            else begin
               k = (b * NR + row_m[b]) * NC + oh_index(NR'(cs));
               if (we) mem_m[k] = wd;
               else begin
                  rd  = 1'b1;
                  chk = mem_m.exists(k);
                  if (chk) dat = mem_m[k];
               end
            end
         end else begin
            if (m_active(b, e)) begin
               open_m[b]  = 1'b0;
               idle_at[b] = e + E_RP;
            end else if (!m_idle(b, e)) err = 1'b1;
         end
      end
      rq.push_back('{cyc: e, val: (e >= rf_end)});
      if (err || rd) eq.push_back('{cyc: e, err: err, chk: chk, data: dat});
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) issue(2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic act(input int b, input int r);
      issue(2'b01, 1'b0, 1'b0, NB'(1) << b, NR'(1) << r, '0, 1'b0);
   endtask

   task automatic wr(input int b, input int c, input logic d);
      issue(2'b10, 1'b1, 1'b0, NB'(1) << b, '0, NC'(1) << c, d);
   endtask

   task automatic rd(input int b, input int c);
      issue(2'b10, 1'b0, 1'b0, NB'(1) << b, '0, NC'(1) << c, 1'b0);
   endtask

   task automatic pre_all();
      for (int b = 0; b < NB; b++) issue(2'b11, 1'b0, 1'b0, NB'(1) << b, '0, '0, 1'b0);
      nop(E_RP);
   endtask

   always @(negedge clk) begin : monitor
      resp_t x;
      rdy_t  y;
      if (!rst) begin
         if (rq.size() > 0 && rq[0].cyc == edge_no) begin
            y = rq.pop_front();
            check("ready", 32'(bus.ready), 32'(y.val));
         end
         if (eq.size() > 0 && eq[0].cyc == edge_no) begin
            x = eq.pop_front();
            check("cmd_err", 32'(bus.cmd_err), 32'(x.err));
            check("rd_valid", 32'(bus.rd_valid), 32'(!x.err));
            if (!x.err && x.chk) check("rd_data", 32'(bus.dram_data_out), 32'(x.data));
         end else if (bus.rd_valid || bus.cmd_err) begin
            check("unexpected_output", {30'd0, bus.rd_valid, bus.cmd_err}, 32'd0);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [NB-1:0] bs;
      logic [NR-1:0] rs;
      logic [NC-1:0] cs;
      int            kind;
      bus.cmd = 2'b00; bus.wr_en = 1'b0; bus.refresh = 1'b0;
      bus.bank_sel = '0; bus.row_sel = '0; bus.col_sel = '0; bus.wr_data = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_data_out", 32'(bus.dram_data_out), 32'd0);
      check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("reset_cmd_err", 32'(bus.cmd_err), 32'd0);
      check("reset_ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // write then read back in an open row
      act(3, 5); nop(E_RCD - 1); wr(3, 2, 1'b1); rd(3, 2); nop(2);

      // read one edge after activate, then retry
      act(0, 4); rd(0, 1); rd(0, 1); nop(2);

      // two banks open at once
      act(1, 7); act(6, 9); nop(E_RCD);
      wr(1, 0, 1'b1); wr(6, 0, 1'b0); rd(1, 0); rd(6, 0); nop(2);

      // refresh with an activate thrown at it mid-refresh
      pre_all();
      issue(2'b00, 1'b0, 1'b1, '0, '0, '0, 1'b0);
      act(2, 1);
      nop(E_RFC);
      act(1, 7); act(6, 9); nop(E_RCD);
      rd(1, 0); rd(6, 0); nop(2);

      // malformed selects leave every bank idle, so refresh is accepted
      pre_all();
      issue(2'b01, 1'b0, 1'b0, 8'b0000_0011, NR'(1) << 3, '0, 1'b0);
      issue(2'b10, 1'b0, 1'b0, NB'(1) << 1, '0, '0, 1'b0);
      issue(2'b00, 1'b0, 1'b1, '0, '0, '0, 1'b0);
      nop(E_RFC + 1);

      // reset while bank 2 activates and a read is in flight
      act(1, 7); nop(E_RCD - 1);
      act(2, 3); rd(1, 0);
      @(posedge clk);
      #2;
      eq.delete(); rq.delete();
      bus.cmd = 2'b00; bus.refresh = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_data_out", 32'(bus.dram_data_out), 32'd0);
      check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("midrst_cmd_err", 32'(bus.cmd_err), 32'd0);
      check("midrst_ready", 32'(bus.ready), 32'd1);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      rd(2, 0); nop(2);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         bs = NB'(1) << $urandom_range(0, NB - 1);
         rs = NR'(1) << $urandom_range(0, 7);
         cs = NC'(1) << $urandom_range(0, NC - 1);
         if ($urandom_range(0, 15) == 0) bs = NB'($urandom);
         if ($urandom_range(0, 15) == 0) rs = rs | (NR'(1) << $urandom_range(0, NR - 1));
         if ($urandom_range(0, 15) == 0) cs = '0;
         kind = $urandom_range(0, 15);
         if (kind < 2)       issue(2'b00, 1'b0, 1'b0, bs, rs, cs, 1'b0);
         else if (kind < 5)  issue(2'b01, 1'b0, 1'b0, bs, rs, cs, 1'b0);
         else if (kind < 11) issue(2'b10, 1'($urandom), 1'b0, bs, rs, cs, 1'($urandom));
         else if (kind < 14) issue(2'b11, 1'b0, 1'b0, bs, rs, cs, 1'b0);
         else if (kind == 14) issue(2'b00, 1'b0, 1'b1, bs, rs, cs, 1'b0);
         else issue(2'($urandom_range(1, 3)), 1'b0, 1'b1, bs, rs, cs, 1'b0);
      end
      nop(E_RFC + 4);
      @(negedge clk);
      check("pending_responses", 32'(eq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dram_bank_array.md
# dram_bank_array

Device-side responder for the DRAM controller command interface. It decodes the controller's 2-bit `cmd` together with the one-hot `bank_sel`/`row_sel`/`col_sel` selects, and tracks an open row and timing state for each bank. It stores data in an internal bit array, returns read data to the controller's `dram_data_in`, and flags protocol violations. It is the synthesizable far end that the controller FSM drives in integration and verification.

## Interface
- `NUM_OF_BANKS`, 8: number of banks; `bank_sel` width.
- `NUM_OF_ROWS`, 128: rows per bank; `row_sel` width.
- `NUM_OF_COLS`, 8: columns per row; `col_sel` width.
- `DATA_WIDTH`, 1: bits per column.
- `T_RCD`, 2: activate-to-active cycles, at least 1.
- `T_RP`, 2: precharge-to-idle cycles, at least 1.
- `T_RFC`, 8: refresh busy cycles, at least 1.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd`, in, 2: 00 NOP, 01 ACTIVATE, 10 READ/WRITE, 11 PRECHARGE.
- `wr_en`, in, 1: with cmd=10, 1 = WRITE, 0 = READ.
- `refresh`, in, 1: refresh request; legal only with cmd=NOP.
- `bank_sel`, in, NUM_OF_BANKS: one-hot bank select.
- `row_sel`, in, NUM_OF_ROWS: one-hot row select; used by ACTIVATE only.
- `col_sel`, in, NUM_OF_COLS: one-hot column select; used by READ/WRITE only.
- `wr_data`, in, DATA_WIDTH: write data, sampled with WRITE.
- `dram_data_out`, out, DATA_WIDTH: read data; connects to controller `dram_data_in`.
- `rd_valid`, out, 1: `dram_data_out` is valid this cycle.
- `ready`, out, 1: commands accepted; low while refreshing.
- `cmd_err`, out, 1: one-cycle pulse marking a rejected command.

## Operation
- Per-bank FSM has four states: IDLE, ACTIVATING, ACTIVE, PRECHARGING. Each bank holds an open-row index register of width log2(NUM_OF_ROWS).
- ACTIVATE, bank IDLE: latch the row index decoded from `row_sel`, then enter ACTIVATING with a counter of T_RCD. The bank moves to ACTIVE when the counter expires.
- READ, bank ACTIVE: read array[bank][open_row][col].
- WRITE, bank ACTIVE: array[bank][open_row][col] <= `wr_data`.
- PRECHARGE, bank ACTIVE: enter PRECHARGING with a counter of T_RP, then return to IDLE.
- PRECHARGE, bank IDLE: legal no-op, no error.
- Refresh is accepted when `refresh`=1, cmd=NOP, and all banks are IDLE. It drops `ready` for T_RFC cycles. The array contents are retained.
- Rejected commands pulse `cmd_err` and change no state. A command is rejected when any of the following holds:
  - any used select (bank always; row for ACTIVATE; col for READ/WRITE) is not one-hot;
  - ACTIVATE targets a bank that is not IDLE;
  - READ/WRITE targets a bank that is not ACTIVE;
  - PRECHARGE targets a bank that is ACTIVATING or PRECHARGING;
  - any command or refresh is issued while `ready`=0;
  - refresh is issued with a non-NOP cmd, in which case both are rejected;
  - refresh is issued while any bank is not IDLE.
- NOP with `refresh`=0 is never an error; the selects are ignored.
- Banks are independent. A command to one bank proceeds while other banks are counting down.

## Timing
- Reset values:
  - `dram_data_out`=0, `rd_valid`=0, `cmd_err`=0, `ready`=1.
  - All banks IDLE, all counters 0, open rows 0.
  - Array contents are not reset.
- Reset asserted mid-operation aborts every activate, precharge and refresh immediately. Pending `rd_valid` and `cmd_err` are cleared.
- Read latency is 1 cycle: a READ sampled on edge N drives `dram_data_out` and `rd_valid`=1 during cycle N+1. `dram_data_out` holds its last value when `rd_valid`=0.
- A WRITE is visible to a READ issued on the next edge.
- ACTIVATE on edge N: bank is ACTIVE and READ/WRITE is legal from edge N+T_RCD.
- PRECHARGE on edge N: bank is IDLE from edge N+T_RP.
- Refresh on edge N: `ready`=0 for cycles N+1 through N+T_RFC; commands are legal again at edge N+T_RFC+1.
- `cmd_err` rises in the cycle after the offending edge and lasts exactly 1 cycle.

## Configuration
- `DRAM_BANK_ARRAY_TIMING_CHECK_EN` defined:
  - T_RCD, T_RP and T_RFC counters are built.
  - Commands issued during ACTIVATING, PRECHARGING or refresh raise `cmd_err`.
- Not defined:
  - Counters are omitted; every transition completes in 1 cycle. ACTIVATE on edge N gives ACTIVE at N+1; PRECHARGE gives IDLE at N+1; refresh holds `ready` low for 1 cycle.
  - All other error checks remain.

## Test plan
- Write/read: ACTIVATE bank 3 row 5; wait T_RCD; WRITE col 2 `wr_data`=1; READ col 2. Expect `rd_valid`=1 with `dram_data_out`=1 one cycle after the READ, and `cmd_err` never set.
- Early access: ACTIVATE bank 0, then READ bank 0 on the next edge (T_RCD=2, macro defined). Expect a `cmd_err` pulse, no `rd_valid`, and a legal READ on the following edge.
- Bank interleave: ACTIVATE bank 1 row 7 and bank 6 row 9; write 1 to bank 1 col 0 and 0 to bank 6 col 0; read both back. Expect 1 and 0, each at 1-cycle latency.
- Refresh: with all banks IDLE, pulse `refresh` with NOP. Expect `ready`=0 for 8 cycles; an ACTIVATE issued during refresh gives `cmd_err`; previously written data is intact afterwards.
- Illegal selects: ACTIVATE with `bank_sel`=8'b0000_0011, then READ with `col_sel`=0. Expect two `cmd_err` pulses and all banks still IDLE.
- Reset mid-activate: assert `rst` while bank 2 is ACTIVATING. Expect all outputs at their reset values, bank 2 IDLE, and a READ to bank 2 after reset giving `cmd_err`.
